// File: rtl/draw_cmd_scheduler_pkg.sv
// Shared definitions for the draw command scheduler: pixel geometry, engine mode
// encodings, scheduler state encoding and the command normalisation helper.
package draw_cmd_scheduler_pkg;

  localparam int unsigned PIXEL_X_WIDTH  = 10;
  localparam int unsigned PIXEL_Y_WIDTH  = 9;
  localparam int unsigned PIXEL_X_MAX    = 639;
  localparam int unsigned PIXEL_Y_MAX    = 479;
  localparam int unsigned COLOR_ID_WIDTH = 8;
  localparam int unsigned TMO_CNT_WIDTH  = 20;

  typedef logic [PIXEL_X_WIDTH-1:0]  px_x_t;
  typedef logic [PIXEL_Y_WIDTH-1:0]  px_y_t;
  typedef logic [COLOR_ID_WIDTH-1:0] color_t;

  localparam px_x_t XMax = px_x_t'(PIXEL_X_MAX);
  localparam px_y_t YMax = px_y_t'(PIXEL_Y_MAX);

  typedef enum logic [1:0] {
    ModeSetP0        = 2'b00,
    ModeSetP1Start   = 2'b01,
    ModeSetBothStart = 2'b10
  } eng_mode_e;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } sched_state_e;

  typedef struct packed {
    px_x_t  x0;
    px_y_t  y0;
    px_x_t  x1;
    px_y_t  y1;
    color_t color;
  } draw_cmd_t;

  // Clamp to the visible area, then order corners so x0 <= x1 and y0 <= y1.
  function automatic draw_cmd_t normalize_cmd(input logic clear, input px_x_t x0, input px_x_t x1,
                                              input px_y_t y0, input px_y_t y1,
                                              input color_t color);
    draw_cmd_t c;
    px_x_t     ax, bx;
    px_y_t     ay, by;
    ax = (x0 > XMax) ? XMax : x0;
    bx = (x1 > XMax) ? XMax : x1;
    ay = (y0 > YMax) ? YMax : y0;
    by = (y1 > YMax) ? YMax : y1;
    c.color = color;
    if (clear) begin
      c.x0 = '0;
      c.y0 = '0;
      c.x1 = XMax;
      c.y1 = YMax;
    end else begin
      c.x0 = (ax <= bx) ? ax : bx;
      c.x1 = (ax <= bx) ? bx : ax;
      c.y0 = (ay <= by) ? ay : by;
      c.y1 = (ay <= by) ? by : ay;
    end
    return c;
  endfunction

endpackage

// File: rtl/draw_cmd_scheduler_if.sv
// User-side command handshake into the draw command scheduler.
interface draw_cmd_scheduler_if;
  import draw_cmd_scheduler_pkg::*;

  logic   cmd_vld;
  logic   cmd_rdy;
  logic   cmd_type;
  px_x_t  cmd_x0;
  px_x_t  cmd_x1;
  px_y_t  cmd_y0;
  px_y_t  cmd_y1;
  color_t cmd_color;

  modport master (
    output cmd_vld, cmd_type, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    input  cmd_rdy
  );

  modport slave (
    input  cmd_vld, cmd_type, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    output cmd_rdy
  );
endinterface

// File: rtl/draw_cmd_scheduler_fifo.sv
// Synchronous command FIFO with flush; Depth must be a power of two >= 2.
module draw_cmd_scheduler_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [Width-1:0]       wdata,
  output logic [Width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);
  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AddrW + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AddrW + 1)'(1);
        2'b01:   count_q <= count_q - (AddrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/draw_cmd_scheduler.sv
// Queues normalised fill/clear commands and hands them to the fill engine one at a
// time, waiting for the engine's done pulse (or a timeout) between commands.
module draw_cmd_scheduler
  import draw_cmd_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 310000
) (
  input  logic                        clk,
  input  logic                        rst,
  draw_cmd_scheduler_if.slave         cmd,
  input  logic                        flush,
  input  logic                        err_clr,
  output px_x_t                       eng_x0,
  output px_x_t                       eng_x1,
  output px_y_t                       eng_y0,
  output px_y_t                       eng_y1,
  output logic [1:0]                  eng_mode,
  output color_t                      eng_data,
  output logic                        eng_vld,
  input  logic                        eng_done,
  output logic                        cmd_done,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        err_timeout
);
  localparam logic [TMO_CNT_WIDTH-1:0] TimeoutLast = TMO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  sched_state_e             state_q, state_d;
  draw_cmd_t                norm_cmd, fifo_rdata, eng_q;
  logic                     fifo_full, fifo_empty, push;
  logic                     issue, complete, expire;
  logic                     eng_vld_q, cmd_done_q, err_q;
  logic [TMO_CNT_WIDTH-1:0] tmo_cnt_q;

  // Held low during reset so every output except the constant mode reads zero.
  assign cmd.cmd_rdy = rst & ~fifo_full;
  assign push        = cmd.cmd_vld & cmd.cmd_rdy;
  assign norm_cmd    = normalize_cmd(cmd.cmd_type, cmd.cmd_x0, cmd.cmd_x1, cmd.cmd_y0,
                                     cmd.cmd_y1, cmd.cmd_color);

  draw_cmd_scheduler_fifo #(
    .Width ($bits(draw_cmd_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (issue),
    .flush (flush),
    .wdata (norm_cmd),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty && !flush) state_d = StWait;
      StWait:  if (eng_done || tmo_cnt_q == TimeoutLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A flush in IDLE drops the head too, so it also blocks the issue.
  always_comb begin
    issue    = 1'b0;
    complete = 1'b0;
    expire   = 1'b0;
    unique case (state_q)
      StIdle: issue = !fifo_empty && !flush;
      StWait: begin
        complete = eng_done;
        expire   = !eng_done && (tmo_cnt_q == TimeoutLast);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_q      <= '0;
      eng_vld_q  <= 1'b0;
      cmd_done_q <= 1'b0;
      err_q      <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      eng_vld_q  <= issue;
      cmd_done_q <= complete;
      if (issue) eng_q <= fifo_rdata;
      if (expire)       err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
      if (issue) begin
        tmo_cnt_q <= '0;
      end else if (state_q == StWait && tmo_cnt_q != '1) begin
        tmo_cnt_q <= tmo_cnt_q + TMO_CNT_WIDTH'(1);
      end
    end
  end

  assign eng_x0      = eng_q.x0;
  assign eng_y0      = eng_q.y0;
  assign eng_x1      = eng_q.x1;
  assign eng_y1      = eng_q.y1;
  assign eng_data    = eng_q.color;
  assign eng_mode    = ModeSetBothStart;
  assign eng_vld     = eng_vld_q;
  assign cmd_done    = cmd_done_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != StIdle) || !fifo_empty;
endmodule

// File: tb/tb_draw_cmd_scheduler.sv
// Directed bench for draw_cmd_scheduler with a scoreboard of expected engine commands.
module tb_draw_cmd_scheduler;
  import draw_cmd_scheduler_pkg::*;

  localparam int unsigned Tmo = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0, err_clr = 1'b0, eng_done = 1'b0;
  px_x_t      eng_x0, eng_x1;
  px_y_t      eng_y0, eng_y1;
  logic [1:0] eng_mode;
  color_t     eng_data;
  logic       eng_vld, cmd_done, busy, err_timeout;
  logic [2:0] fifo_count;

  int        vectors = 0;
  int        errors = 0;
  int        vld_cnt = 0;
  draw_cmd_t exp_q[$];
  draw_cmd_t exp_cmd;

  draw_cmd_scheduler_if cmd_if ();

  draw_cmd_scheduler #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if),
    .flush       (flush),
    .err_clr     (err_clr),
    .eng_x0      (eng_x0),
    .eng_x1      (eng_x1),
    .eng_y0      (eng_y0),
    .eng_y1      (eng_y1),
    .eng_mode    (eng_mode),
    .eng_data    (eng_data),
    .eng_vld     (eng_vld),
    .eng_done    (eng_done),
    .cmd_done    (cmd_done),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic draw_cmd_t model(input bit clr, input int x0, input int y0, input int x1,
                                      input int y1, input int col);
    int        cx0, cx1, cy0, cy1;
    draw_cmd_t m;
    cx0 = (x0 > 639) ? 639 : x0;
    cx1 = (x1 > 639) ? 639 : x1;
    cy0 = (y0 > 479) ? 479 : y0;
    cy1 = (y1 > 479) ? 479 : y1;
    if (clr) begin
      cx0 = 0; cy0 = 0; cx1 = 639; cy1 = 479;
    end
    m.x0    = px_x_t'((cx0 < cx1) ? cx0 : cx1);
    m.x1    = px_x_t'((cx0 < cx1) ? cx1 : cx0);
    m.y0    = px_y_t'((cy0 < cy1) ? cy0 : cy1);
    m.y1    = px_y_t'((cy0 < cy1) ? cy1 : cy0);
    m.color = color_t'(col);
    return m;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input bit clr, input int x0, input int y0, input int x1, input int y1,
                          input int col);
    logic rdy;
    cmd_if.cmd_type  = clr;
    cmd_if.cmd_x0    = px_x_t'(x0);
    cmd_if.cmd_y0    = px_y_t'(y0);
    cmd_if.cmd_x1    = px_x_t'(x1);
    cmd_if.cmd_y1    = px_y_t'(y1);
    cmd_if.cmd_color = color_t'(col);
    cmd_if.cmd_vld   = 1'b1;
    rdy = cmd_if.cmd_rdy;
    @(posedge clk);
    if (rdy) exp_q.push_back(model(clr, x0, y0, x1, y1, col));
    #1 cmd_if.cmd_vld = 1'b0;
  endtask

  task automatic finish_cmd(input string tag);
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    check({tag, "_cmd_done"}, cmd_done, 1'b1);
  endtask

  // Scoreboard: every engine issue must match the oldest accepted command.
  always @(negedge clk) begin
    if (rst && eng_vld) begin
      vld_cnt++;
      check("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_cmd = exp_q.pop_front();
        check("sb_x0", eng_x0, exp_cmd.x0);
        check("sb_y0", eng_y0, exp_cmd.y0);
        check("sb_x1", eng_x1, exp_cmd.x1);
        check("sb_y1", eng_y1, exp_cmd.y1);
        check("sb_data", eng_data, exp_cmd.color);
        check("sb_mode", eng_mode, 2'b10);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vld_snap;
    int xs0[6] = '{50, 1000, 3, 639, 200, 1};
    int ys0[6] = '{60, 0, 3, 479, 100, 2};
    int xs1[6] = '{40, 0, 3, 0, 300, 3};
    int ys1[6] = '{30, 511, 3, 0, 50, 4};
    int cols[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    cmd_if.cmd_vld = 1'b0; cmd_if.cmd_type = 1'b0; cmd_if.cmd_color = '0;
    cmd_if.cmd_x0 = '0; cmd_if.cmd_x1 = '0; cmd_if.cmd_y0 = '0; cmd_if.cmd_y1 = '0;
    #2 rst = 1'b0;
    tick(2);
    check("rst_eng_vld", eng_vld, 1'b0);
    check("rst_eng_x1", eng_x1, 0);
    check("rst_eng_mode", eng_mode, 2'b10);
    check("rst_cmd_rdy", cmd_if.cmd_rdy, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_cmd_done", cmd_done, 1'b0);
    rst = 1'b1;
    tick(1);
    check("idle_cmd_rdy", cmd_if.cmd_rdy, 1'b1);

    // Basic rectangle: issue one cycle after the push edge, done 8 cycles later.
    push_cmd(0, 10, 20, 12, 21, 8'h3C);
    check("t1_busy", busy, 1'b1);
    tick(1);
    check("t1_eng_vld", eng_vld, 1'b1);
    check("t1_x0", eng_x0, 10);
    check("t1_y0", eng_y0, 20);
    check("t1_x1", eng_x1, 12);
    check("t1_y1", eng_y1, 21);
    check("t1_data", eng_data, 8'h3C);
    tick(1);
    check("t1_vld_pulse", eng_vld, 1'b0);
    tick(6);
    finish_cmd("t1");
    check("t1_busy_fall", busy, 1'b0);
    tick(1);
    check("t1_done_pulse", cmd_done, 1'b0);
    check("t1_hold_x0", eng_x0, 10);

    // Out-of-range swapped corners.
    push_cmd(0, 700, 500, 5, 3, 8'h5A);
    tick(1);
    check("t2_x0", eng_x0, 5);
    check("t2_y0", eng_y0, 3);
    check("t2_x1", eng_x1, 639);
    check("t2_y1", eng_y1, 479);
    finish_cmd("t2");

    // Clear screen ignores coordinates.
    tick(1);
    push_cmd(1, 100, 200, 30, 40, 8'h00);
    tick(1);
    check("t3_x0", eng_x0, 0);
    check("t3_y0", eng_y0, 0);
    check("t3_x1", eng_x1, 639);
    check("t3_y1", eng_y1, 479);
    check("t3_data", eng_data, 8'h00);
    finish_cmd("t3");
    tick(1);

    // Six back-to-back: one issued, four queued, sixth refused.
    for (int i = 0; i < 5; i++) push_cmd(0, xs0[i], ys0[i], xs1[i], ys1[i], cols[i]);
    check("t4_rdy_full", cmd_if.cmd_rdy, 1'b0);
    check("t4_count_full", fifo_count, 4);
    push_cmd(0, xs0[5], ys0[5], xs1[5], ys1[5], cols[5]);
    for (int i = 0; i < 5; i++) begin
      finish_cmd("t4");
      if (i < 4) begin
        check("t4_vld_gap", eng_vld, 1'b0);
        tick(1);
        check("t4_vld_issue", eng_vld, 1'b1);
      end
    end
    check("t4_sb_drained", exp_q.size(), 0);
    check("t4_busy_end", busy, 1'b0);
    tick(1);

    // Timeout after exactly Tmo cycles, then the queued command goes out.
    push_cmd(0, 1, 1, 2, 2, 8'hA1);
    push_cmd(0, 3, 3, 4, 4, 8'hA2);
    check("t5_vld", eng_vld, 1'b1);
    tick(Tmo - 1);
    check("t5_err_early", err_timeout, 1'b0);
    tick(1);
    check("t5_err_set", err_timeout, 1'b1);
    check("t5_no_done", cmd_done, 1'b0);
    tick(1);
    check("t5_next_vld", eng_vld, 1'b1);
    check("t5_next_x0", eng_x0, 3);
    finish_cmd("t5");
    check("t5_err_sticky", err_timeout, 1'b1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t5_err_clr", err_timeout, 1'b0);

    // Asynchronous reset mid-WAIT with three queued.
    for (int i = 0; i < 4; i++) push_cmd(0, 10 * i, 5, 20, 6, i);
    check("t6_count3", fifo_count, 3);
    #2 rst = 1'b0;
    #1;
    check("t6_async_count", fifo_count, 0);
    check("t6_async_x0", eng_x0, 0);
    check("t6_async_data", eng_data, 0);
    check("t6_async_busy", busy, 1'b0);
    exp_q.delete();
    tick(1);
    rst = 1'b1;
    vld_snap = vld_cnt;
    tick(5);
    check("t6_no_vld", vld_cnt, vld_snap);
    check("t6_idle", busy, 1'b0);

    // Flush in WAIT drops the queue but not the running command.
    for (int i = 0; i < 4; i++) push_cmd(0, 5, 10 * i, 6, 20, 8'hB0 + i);
    check("t7_count3", fifo_count, 3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    exp_q.delete();
    check("t7_flushed", fifo_count, 0);
    check("t7_busy_wait", busy, 1'b1);
    vld_snap = vld_cnt;
    finish_cmd("t7");
    tick(3);
    check("t7_no_vld", vld_cnt, vld_snap);
    check("t7_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/draw_cmd_scheduler.md
Name: draw_cmd_scheduler

Overview:
Queues rectangle-fill and clear-screen commands from the CPU/user side and issues them one at a time to the rectangle fill engine. The engine has no backpressure and no coordinate checking, so this block enforces that contract: it normalises coordinates and waits for the engine's done pulse before sending the next command. It sits between the user command interface and the fill engine's USER IF; the engine drives the VGA RAM port directly.

Parameters:
PIXEL_X_WIDTH, 10, x coordinate width
PIXEL_Y_WIDTH, 9, y coordinate width
PIXEL_X_MAX, 639, last visible column
PIXEL_Y_MAX, 479, last visible row
COLOR_ID_WIDTH, 8, colour index width
FIFO_DEPTH, 4, command queue entries (power of 2)
TIMEOUT_CYCLES, 310000, cycles allowed in WAIT before abandoning a command (must be > 640*480)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
cmd_vld  in  1  command valid
cmd_rdy  out  1  queue can accept a command; equals !full
cmd_type  in  1  0 = rectangle, 1 = clear screen
cmd_x0, cmd_x1  in  PIXEL_X_WIDTH  rectangle corner columns
cmd_y0, cmd_y1  in  PIXEL_Y_WIDTH  rectangle corner rows
cmd_color  in  COLOR_ID_WIDTH  fill colour
flush  in  1  drop all queued commands
err_clr  in  1  clear err_timeout
eng_x0, eng_x1  out  PIXEL_X_WIDTH  to engine x0/x1
eng_y0, eng_y1  out  PIXEL_Y_WIDTH  to engine y0/y1
eng_mode  out  2  to engine mode; constant 2'b10
eng_data  out  COLOR_ID_WIDTH  to engine idata
eng_vld  out  1  to engine idata_vld; single-cycle pulse
eng_done  in  1  from engine odone
cmd_done  out  1  1-cycle pulse per completed command
busy  out  1  state != IDLE or queue not empty
fifo_count  out  clog2(FIFO_DEPTH)+1  queued entries
err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): all outputs 0 except eng_mode=2'b10; queue empty; state IDLE; timeout counter 0. Reset asserted mid-WAIT abandons the command; the engine is not notified.
- Push: on cmd_vld & cmd_rdy at a rising edge, normalise the command and write it to the queue.
- Normalisation, applied at push:
  - Clamp each x to PIXEL_X_MAX and each y to PIXEL_Y_MAX.
  - After clamping, swap so x0 <= x1 and y0 <= y1.
  - cmd_type=1 ignores the coordinates and stores (0,0)-(PIXEL_X_MAX,PIXEL_Y_MAX).
- cmd_rdy=!full. It does not account for a same-cycle pop.
- FSM states: IDLE, WAIT.
  - IDLE, queue non-empty: pop the head, register eng_x0/y0/x1/y1/eng_data, pulse eng_vld for 1 cycle, clear the timeout counter, go to WAIT.
  - IDLE, queue empty: stay.
  - WAIT, eng_done=1: pulse cmd_done, go to IDLE.
  - WAIT, counter = TIMEOUT_CYCLES-1 with no eng_done: set err_timeout, no cmd_done, go to IDLE.
  - WAIT otherwise: increment counter (20-bit, saturating).
  - eng_done in IDLE is ignored.
- Latency and spacing:
  - A command pushed into an empty queue while IDLE produces eng_vld in the cycle after the push edge.
  - Back-to-back issues are separated by at least one IDLE cycle after eng_done.
- eng_* coordinate and data outputs hold their values until the next issue.
- flush: empties the queue on that edge and has priority over a same-cycle push. It does not abort WAIT.
- err_timeout: set has priority over err_clr in the same cycle.

Decomposition:
- Shared package/header draw_defs holds: pixel widths, PIXEL_X/Y_MAX, COLOR_ID_WIDTH, the mode encodings (00 set p0, 01 set p1 and start, 10 set both and start), and the scheduler state encoding.
- One sub-module: draw_cmd_fifo, a synchronous FIFO with async active-low reset.
  - Width = 2*PIXEL_X_WIDTH + 2*PIXEL_Y_WIDTH + COLOR_ID_WIDTH.
  - Ports: push, pop, flush, full, empty, count.
- Normalisation logic and FSM live in the top module.

Test Plan:
- Rectangle (10,20)-(12,21), colour 8'h3C, into idle block -> next cycle one eng_vld pulse with x0=10, y0=20, x1=12, y1=21, mode=2'b10, data=8'h3C; eng_done 8 cycles later -> cmd_done pulse the following cycle, busy falls.
- Rectangle (700,500)-(5,3) -> eng_x0=5, eng_y0=3, eng_x1=639, eng_y1=479.
- Clear screen with colour 8'h00 and arbitrary coordinates -> eng (0,0)-(639,479), data 8'h00.
- Six back-to-back commands, eng_done held low:
  - First is issued; four are queued; sixth sees cmd_rdy=0 and fifo_count=4.
  - Then five eng_done pulses -> five eng_vld pulses in FIFO order, each at least 2 cycles after the previous eng_done.
- TIMEOUT_CYCLES=16, no eng_done -> err_timeout=1 exactly 16 cycles after eng_vld, next queued command issued; err_clr -> err_timeout=0.
- rst driven low mid-WAIT with 3 queued -> outputs 0 asynchronously, fifo_count=0; after release, no eng_vld until a new push. flush in WAIT with 3 queued -> fifo_count=0, current eng_done still yields cmd_done.
